// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared state encodings, constants and sizing helper for the I2C controller front-end
package i2c_ctrl_pkg;

    typedef enum logic [1:0] {MODE_IDLE, MODE_SLAVE, MODE_PEND, MODE_MASTER} mode_t;
    typedef enum logic {XF_ISSUE, XF_WAIT} xfer_t;

    localparam logic [7:0] DEFAULT_SCL_DIV = 8'h01;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock FIFO with occupancy count and synchronous flush
module i2c_sync_fifo
    import i2c_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2c_ctrl_fifo_top.sv
// i2c_ctrl_fifo_top: host-side FIFO front-end, filtered bus monitor and mode FSM for the I2C byte engines
module i2c_ctrl_fifo_top
    import i2c_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 8,
    parameter int         FILT_LEN     = 3,
    parameter int         IDLE_TIMEOUT = 1024,
    parameter int         NUM_ADDR     = 2,
    parameter logic [6:0] DEFAULT_ADDR = 7'h49
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [7:0]                     set_scl_div,
    output logic [7:0]                     scl_div,
    input  logic [7*NUM_ADDR-1:0]          set_local_addr,
    output logic [7*NUM_ADDR-1:0]          local_addr,
    input  logic                           start_req,
    input  logic                           stop_req,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic [7:0]                     tx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [7:0]                     rx_data,
    output logic [level_w(FIFO_DEPTH)-1:0] tx_level,
    output logic [level_w(FIFO_DEPTH)-1:0] rx_level,
    output logic [7:0]                     eng_byte_wr,
    output logic                           eng_wr_rdy,
    input  logic                           eng_wr_reg_empty,
    input  logic [7:0]                     eng_byte_rd,
    input  logic                           eng_rd_reg_full,
    output logic                           eng_rd_clr,
    output logic                           eng_start_trans,
    output logic                           eng_stop_trans,
    input  logic                           eng_arbit_fail,
    input  logic                           eng_trans_stop,
    output logic                           master_en,
    output logic                           slave_en,
    input  logic                           scl_i,
    input  logic                           sda_i,
    output logic                           bus_busy,
    output logic                           is_master,
    output logic                           start_pending,
    output logic                           bus_timeout
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]    meta, sync, filt, filt_d;
    logic [FW-1:0] fcnt [2];
    logic [TW-1:0] idle_cnt;
    logic          start_det, stop_det, idle;
    mode_t         mode, mode_nx;
    xfer_t         tx_st, tx_nx, rx_st, rx_nx;
    logic          tx_fire, rx_fire, tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]    tx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_div    <= DEFAULT_SCL_DIV;
            local_addr <= {NUM_ADDR{DEFAULT_ADDR}};
        end else if (!enable) begin
            scl_div    <= (set_scl_div == 8'h00) ? 8'h01 : set_scl_div;
            local_addr <= set_local_addr;
        end
    end

    // bit 0 carries scl, bit 1 carries sda
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '1;
            sync   <= '1;
            filt   <= '1;
            filt_d <= '1;
            fcnt   <= '{default: '0};
        end else begin
            meta   <= {sda_i, scl_i};
            sync   <= meta;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= (sync[i] == filt[i] || fcnt[i] == FW'(FILT_LEN - 1)) ? '0 : fcnt[i] + FW'(1);
                if (sync[i] != filt[i] && fcnt[i] == FW'(FILT_LEN - 1)) filt[i] <= sync[i];
            end
        end
    end

    assign start_det = filt[0] && filt_d[1] && !filt[1];
    assign stop_det  = filt[0] && !filt_d[1] && filt[1];
    assign idle      = bus_busy && filt[0] && filt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_busy    <= 1'b0;
            bus_timeout <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            bus_timeout <= 1'b0;
            if (start_det) begin
                bus_busy <= 1'b1;
                idle_cnt <= '0;
            end else if (stop_det || !idle) begin
                bus_busy <= bus_busy && !stop_det;
                idle_cnt <= '0;
            end else if (idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
                bus_busy    <= 1'b0;
                bus_timeout <= 1'b1;
                idle_cnt    <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    always_comb begin
        mode_nx = mode;
        case (mode)
            MODE_IDLE:   mode_nx = MODE_SLAVE;
            MODE_SLAVE:  mode_nx = start_req ? MODE_PEND : MODE_SLAVE;
            MODE_PEND:   mode_nx = bus_busy ? MODE_PEND : MODE_MASTER;
            MODE_MASTER: mode_nx = (eng_arbit_fail || eng_trans_stop) ? MODE_SLAVE : MODE_MASTER;
            default:     mode_nx = MODE_IDLE;
        endcase
        if (!enable) mode_nx = MODE_IDLE;
        tx_nx = tx_fire ? XF_WAIT : (tx_st == XF_WAIT && !eng_wr_reg_empty) ? XF_ISSUE : tx_st;
        rx_nx = rx_fire ? XF_WAIT : (rx_st == XF_WAIT && !eng_rd_reg_full) ? XF_ISSUE : rx_st;
    end

    assign master_en     = mode == MODE_MASTER;
    assign slave_en      = mode == MODE_SLAVE || mode == MODE_PEND;
    assign is_master     = master_en;
    assign start_pending = mode == MODE_PEND;
    assign tx_fire       = tx_st == XF_ISSUE && eng_wr_reg_empty && !tx_empty && (master_en || slave_en);
    assign rx_fire       = rx_st == XF_ISSUE && eng_rd_reg_full && !rx_full && enable;
    assign tx_ready      = !tx_full;
    assign rx_valid      = !rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode            <= MODE_IDLE;
            tx_st           <= XF_ISSUE;
            rx_st           <= XF_ISSUE;
            eng_start_trans <= 1'b0;
            eng_stop_trans  <= 1'b0;
            eng_wr_rdy      <= 1'b0;
            eng_rd_clr      <= 1'b0;
            eng_byte_wr     <= 8'h00;
        end else begin
            mode            <= mode_nx;
            tx_st           <= tx_nx;
            rx_st           <= rx_nx;
            eng_start_trans <= (mode == MODE_PEND && mode_nx == MODE_MASTER) ||
                               (mode == MODE_MASTER && mode_nx == MODE_MASTER && start_req);
            eng_stop_trans  <= mode == MODE_MASTER && mode_nx == MODE_MASTER && stop_req;
            eng_wr_rdy      <= tx_fire;
            eng_rd_clr      <= rx_fire;
            if (tx_fire) eng_byte_wr <= tx_head;
        end
    end

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!enable),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (tx_fire),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!enable),
        .push  (rx_fire),
        .wdata (eng_byte_rd),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

endmodule
